hs_mezz_pattern_gen: RTL and testbench

Parametrised bring-up pattern generator for the Ultra96v2 high-speed mezzanine outputs (CSI0/CSI1 data, clock and MCLK, DSI, HSIC). It drives NUM_CH independent output channels of CH_W bits. Each channel runs its own mode: off, static, walking-one, binary count or PRBS, with its own step divider. It sits between the PS-side configuration logic and the hs_mezz_* top-level pins, replacing hard-wired tie-offs so board and cable bring-up can be done per lane.

---
 rtl/hs_mezz_pkg.sv | 50 +++++
 rtl/hs_mezz_pattern_ch.sv | 129 ++++++++++++
 rtl/hs_mezz_pattern_gen.sv | 83 ++++++++
 tb/tb_hs_mezz_pattern_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_mezz_pkg.sv
// ---------------------------------------------------------------------------
// hs_mezz_pkg
// Shared definitions for the high-speed mezzanine pattern generator:
//   - mode codes for a channel (OFF, STATIC, WALK, COUNT, PRBS)
//   - PRBS seed and Galois tap mask (x^16 + x^14 + x^13 + x^11 + 1)
//   - channel count / channel width limits
//   - helpers to decode a raw mode code and to advance the PRBS register
// ---------------------------------------------------------------------------
package hs_mezz_pkg;

  localparam int MAX_CH   = 16;
  localparam int MAX_CH_W = 16;
  localparam int STATE_W  = 16;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_STATIC = 3'd1,
    MODE_WALK   = 3'd2,
    MODE_COUNT  = 3'd3,
    MODE_PRBS   = 3'd4
  } mode_e;

  localparam logic [STATE_W-1:0] PRBS_SEED = 16'hACE1;
  localparam logic [STATE_W-1:0] PRBS_TAPS = 16'hB400;

  // Codes 5..7 are not defined and behave exactly like OFF.
  function automatic mode_e decode_mode(input logic [2:0] code);
    mode_e m;
    case (code)
      3'd1:    m = MODE_STATIC;
      3'd2:    m = MODE_WALK;
      3'd3:    m = MODE_COUNT;
      3'd4:    m = MODE_PRBS;
      default: m = MODE_OFF;
    endcase
    return m;
  endfunction

  // Right-shifting Galois LFSR: the bit shifted out of bit 0 folds the
  // tap mask back into the register.
  function automatic logic [STATE_W-1:0] prbs_next(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ PRBS_TAPS;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_mezz_pattern_ch.sv
// ---------------------------------------------------------------------------
// hs_mezz_pattern_ch
// One pattern channel: mode/div/cnt/state registers, step divider and the
// per-mode state advance.
//
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   en         - run enable; low freezes cnt and state
//   we         - configuration write aimed at this channel
//   cfg_mode   - raw mode code (5..7 decode to OFF)
//   cfg_value  - STATIC value / COUNT start value
//   cfg_div    - step period minus one
//   pat_out    - registered low CH_W bits of the channel state
//   tick       - high in the cycle whose closing edge advances the state
//
// Handshake: 'we' is a one-cycle strobe with no ready; every strobe is
// taken on the edge where it is high and it overrides any step that
// would have happened on that edge.
//
// pat_out is a plain copy of the state delayed by one register, so a new
// state (loaded or stepped) reaches the pin one edge after it is formed.
// ---------------------------------------------------------------------------
module hs_mezz_pattern_ch
  import hs_mezz_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [2:0]       cfg_mode,
  input  logic [CH_W-1:0]  cfg_value,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [CH_W-1:0]  pat_out,
  output logic             tick
);

  mode_e              mode_q, mode_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CH_W-1:0]    pat_q, pat_d;
  logic               step;

  // Initial state loaded by a configuration write.
  function automatic logic [STATE_W-1:0] load_state(input mode_e m,
                                                    input logic [CH_W-1:0] v);
    logic [STATE_W-1:0] r;
    r = '0;
    case (m)
      MODE_STATIC,
      MODE_COUNT: r[CH_W-1:0] = v;
      MODE_WALK:  r = 16'd1;
      MODE_PRBS:  r = PRBS_SEED;
      default:    r = '0;
    endcase
    return r;
  endfunction

  // One step of the pattern. WALK and COUNT live in the low CH_W bits only;
  // PRBS uses the full 16-bit register and shows its low bits.
  function automatic logic [STATE_W-1:0] advance(input mode_e m,
                                                 input logic [STATE_W-1:0] s);
    logic [CH_W-1:0]    lo;
    logic [STATE_W-1:0] r;
    lo = s[CH_W-1:0];
    r  = s;
    case (m)
      MODE_WALK: begin
        r = '0;
        r[CH_W-1:0] = (lo << 1) | (lo >> (CH_W - 1));
      end
      MODE_COUNT: begin
        r = '0;
        r[CH_W-1:0] = lo + CH_W'(1);
      end
      MODE_PRBS: r = prbs_next(s);
      default:   r = s;
    endcase
    return r;
  endfunction

  always_comb begin
    mode_d  = mode_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    step    = 1'b0;
    if (we) begin
      mode_d  = decode_mode(cfg_mode);
      div_d   = cfg_div;
      cnt_d   = '0;
      state_d = load_state(decode_mode(cfg_mode), cfg_value);
    end else if (en) begin
      if (cnt_q == div_q) begin
        cnt_d   = '0;
        step    = 1'b1;
        state_d = advance(mode_q, state_q);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
    pat_d = state_q[CH_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_OFF;
      div_q   <= '0;
      cnt_q   <= '0;
      state_q <= '0;
      pat_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pat_q   <= pat_d;
    end
  end

  // cnt==div is true while reset holds the registers at zero, so the
  // combinational tick is masked by rst to keep it low during reset.
  assign tick    = step & ~rst;
  assign pat_out = pat_q;

endmodule

// File: rtl/hs_mezz_pattern_gen.sv
// ---------------------------------------------------------------------------
// hs_mezz_pattern_gen
// Per-lane bring-up pattern generator for the Ultra96v2 high-speed mezzanine
// outputs. NUM_CH independent channels of CH_W bits, each with its own mode
// (OFF/STATIC/WALK/COUNT/PRBS) and step divider.
//
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   en         - global run enable; low freezes every channel
//   cfg_we     - configuration write strobe (one cycle, always accepted)
//   cfg_ch     - target channel index
//   cfg_mode   - mode code, cfg_value - STATIC/COUNT value,
//   cfg_div    - step period minus one
//   cfg_err    - registered one-cycle pulse after a write to cfg_ch>=NUM_CH
//   pat_out    - channel i at bits [i*CH_W +: CH_W]
//   tick       - per-channel step pulse
//
// Handshake: cfg_we has no ready; a strobe to a valid channel is consumed on
// the edge it is sampled, a strobe to an invalid channel changes nothing
// except raising cfg_err for the following cycle.
// ---------------------------------------------------------------------------
module hs_mezz_pattern_gen
  import hs_mezz_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 8,
  parameter int DIV_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_ch,
  input  logic [2:0]             cfg_mode,
  input  logic [CH_W-1:0]        cfg_value,
  input  logic [DIV_W-1:0]       cfg_div,
  output logic                   cfg_err,
  output logic [NUM_CH*CH_W-1:0] pat_out,
  output logic [NUM_CH-1:0]      tick
);

  logic              ch_bad;
  logic [NUM_CH-1:0] ch_we;
  logic              cfg_err_q, cfg_err_d;

  always_comb begin
    // Compare one bit wider so NUM_CH=16 is representable.
    ch_bad    = ({1'b0, cfg_ch} >= 5'(NUM_CH));
    cfg_err_d = cfg_we & ch_bad;
    ch_we     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_we[i] = cfg_we & (cfg_ch == 4'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hs_mezz_pattern_ch #(
      .CH_W  (CH_W),
      .DIV_W (DIV_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .we        (ch_we[g]),
      .cfg_mode  (cfg_mode),
      .cfg_value (cfg_value),
      .cfg_div   (cfg_div),
      .pat_out   (pat_out[g*CH_W +: CH_W]),
      .tick      (tick[g])
    );
  end

endmodule

// File: tb/tb_hs_mezz_pattern_gen.sv
module tb_hs_mezz_pattern_gen;

  localparam int NUM_CH = 6;
  localparam int CH_W   = 8;
  localparam int DIV_W  = 16;
  localparam int PW     = NUM_CH * CH_W;
  localparam int W      = PW + 1;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              rst;
  logic              en;
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [2:0]        cfg_mode;
  logic [CH_W-1:0]   cfg_value;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_err;
  logic [PW-1:0]     pat_out;
  logic [NUM_CH-1:0] tick;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  hs_mezz_pattern_gen #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_value (cfg_value),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .pat_out   (pat_out),
    .tick      (tick)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic do_check(input string name, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Each channel is described by: mode, divide period, position within the
  // period and the current pattern number. The pin shows the previous
  // edge's pattern.
  int m_mode  [NUM_CH];
  int m_state [NUM_CH];
  int m_cnt   [NUM_CH];
  int m_div   [NUM_CH];
  logic [W-1:0] exp_q[$];
  logic [PW-1:0] pat_e;

  function automatic int next_pattern(input int mode, input int s);
    int lim;
    lim = 1 << CH_W;
    case (mode)
      2: return ((s * 2) % lim) + (s / (lim / 2));       // walking one
      3: return (s + 1) % lim;                           // binary count
      4: return (s % 2 == 1) ? ((s / 2) ^ 'hB400) : (s / 2); // LFSR
      default: return s;
    endcase
  endfunction

  function automatic int first_pattern(input int mode, input int value);
    case (mode)
      1, 3: return value;
      2:    return 1;
      4:    return 'hACE1;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_mode[i] = 0; m_state[i] = 0; m_cnt[i] = 0; m_div[i] = 0;
      end
      exp_q.delete();
    end else begin
      for (int i = 0; i < NUM_CH; i++) pat_e[i*CH_W +: CH_W] = CH_W'(m_state[i]);
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && int'(cfg_ch) == i) begin
          m_mode[i]  = (int'(cfg_mode) > 4) ? 0 : int'(cfg_mode);
          m_div[i]   = int'(cfg_div);
          m_cnt[i]   = 0;
          m_state[i] = first_pattern(m_mode[i], int'(cfg_value));
        end else if (en) begin
          if (m_cnt[i] == m_div[i]) begin
            m_cnt[i]   = 0;
            m_state[i] = next_pattern(m_mode[i], m_state[i]);
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      exp_q.push_back({(cfg_we && int'(cfg_ch) >= NUM_CH), pat_e});
    end
  end

  // ---------------- scoreboard: every cycle at the falling edge ----------------
  logic [W-1:0]      e_cur;
  logic [NUM_CH-1:0] e_tick;

  always @(negedge clk) begin
    if (rst) begin
      do_check("rst_pat", 64'(pat_out), 64'd0);
      do_check("rst_tick", 64'(tick), 64'd0);
      do_check("rst_err", 64'(cfg_err), 64'd0);
    end else begin
      if (exp_q.size() > 0) e_cur = exp_q.pop_front();
      else e_cur = '0;
      do_check("pat", 64'(pat_out), 64'(e_cur[PW-1:0]));
      do_check("err", 64'(cfg_err), 64'(e_cur[W-1]));
      for (int i = 0; i < NUM_CH; i++)
        e_tick[i] = en && (m_cnt[i] == m_div[i]) && !(cfg_we && int'(cfg_ch) == i);
      do_check("tick", 64'(tick), 64'(e_tick));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Returns 2 time units after the edge that sampled the write.
  task automatic cfg_write(input int ch, input int mode, input int value, input int div);
    @(posedge clk); #2;
    cfg_we    = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_mode  = 3'(mode);
    cfg_value = CH_W'(value);
    cfg_div   = DIV_W'(div);
    @(posedge clk); #2;
    cfg_we = 1'b0;
  endtask

  function automatic logic [CH_W-1:0] ch_pat(input int ch);
    return pat_out[ch*CH_W +: CH_W];
  endfunction

  // ---------------- stimulus ----------------
  int ticks;
  logic [7:0] prbs_ref [5];

  initial begin
    prbs_ref[0] = 8'hE1; prbs_ref[1] = 8'h70; prbs_ref[2] = 8'h38;
    prbs_ref[3] = 8'h9C; prbs_ref[4] = 8'h4E;
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_value = '0; cfg_div = '0;

    // Reset defaults
    wait_cycles(3);
    do_check("lit_rst_pat", 64'(pat_out), 64'd0);
    rst = 1'b0; en = 1'b1;
    wait_cycles(5);
    do_check("lit_post_rst_pat", 64'(pat_out), 64'd0);

    // STATIC on ch2
    cfg_write(2, 1, 'hA5, 0);
    do_check("lit_static_latency", 64'(ch_pat(2)), 64'd0);
    wait_cycles(1);
    do_check("lit_static_ch2", 64'(ch_pat(2)), 64'hA5);
    do_check("lit_static_others", 64'(pat_out & ~(48'hFF << 16)), 64'd0);

    // WALK on ch0, div 3
    cfg_write(0, 2, 0, 3);
    wait_cycles(1);
    do_check("lit_walk_init", 64'(ch_pat(0)), 64'h01);
    ticks = 0;
    for (int c = 0; c < 32; c++) begin
      if (c == 4)  do_check("lit_walk_02", 64'(ch_pat(0)), 64'h02);
      if (c == 28) do_check("lit_walk_msb", 64'(ch_pat(0)), 64'h80);
      if (tick[0]) ticks++;
      wait_cycles(1);
    end
    do_check("lit_walk_wrap", 64'(ch_pat(0)), 64'h01);
    do_check("lit_walk_ticks", 64'(ticks), 64'd8);

    // COUNT on ch1 from FE, div 0, with an en pause
    cfg_write(1, 3, 'hFE, 0);
    wait_cycles(1); do_check("lit_count_fe", 64'(ch_pat(1)), 64'hFE);
    wait_cycles(1); do_check("lit_count_ff", 64'(ch_pat(1)), 64'hFF);
    wait_cycles(1); do_check("lit_count_00", 64'(ch_pat(1)), 64'h00);
    wait_cycles(1); do_check("lit_count_01", 64'(ch_pat(1)), 64'h01);
    en = 1'b0;
    #1 do_check("lit_en_off_tick", 64'(tick), 64'd0);
    wait_cycles(5);
    do_check("lit_count_frozen", 64'(ch_pat(1)), 64'h02);
    en = 1'b1;
    wait_cycles(2);
    do_check("lit_count_resume", 64'(ch_pat(1)), 64'h03);

    // PRBS on ch3, div 0
    cfg_write(3, 4, 0, 0);
    for (int k = 0; k < 5; k++) begin
      wait_cycles(1);
      do_check($sformatf("lit_prbs_%0d", k), 64'(ch_pat(3)), 64'(prbs_ref[k]));
    end
    // Rewrite on a cycle that would otherwise step
    cfg_we = 1'b1; cfg_ch = 4'd3; cfg_mode = 3'd4; cfg_div = '0;
    #1;
    do_check("lit_reload_no_tick", 64'(tick[3]), 64'd0);
    do_check("lit_other_tick", 64'(tick[2]), 64'd1);
    wait_cycles(1);
    cfg_we = 1'b0;
    wait_cycles(1);
    do_check("lit_reload_seed", 64'(ch_pat(3)), 64'hE1);

    // Out-of-range channel writes
    cfg_write(NUM_CH, 1, 'h33, 0);
    do_check("lit_err_pulse", 64'(cfg_err), 64'd1);
    do_check("lit_err_ch2_kept", 64'(ch_pat(2)), 64'hA5);
    wait_cycles(1);
    do_check("lit_err_clear", 64'(cfg_err), 64'd0);
    cfg_write(15, 3, 'h00, 1);
    do_check("lit_err_pulse_15", 64'(cfg_err), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      wait_cycles(1);
      en = ($urandom_range(0, 9) != 0);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_ch = 4'($urandom_range(0, 7));
      cfg_mode = 3'($urandom_range(0, 7));
      cfg_value = CH_W'($urandom);
      cfg_div = DIV_W'($urandom_range(0, 3));
    end
    wait_cycles(1);
    cfg_we = 1'b0; en = 1'b1;

    // Reset while running
    cfg_write(2, 1, 'h5A, 0);
    wait_cycles(1);
    do_check("lit_pre_rst_ch2", 64'(ch_pat(2)), 64'h5A);
    rst = 1'b1;
    #1;
    do_check("lit_async_rst_pat", 64'(pat_out), 64'd0);
    do_check("lit_async_rst_tick", 64'(tick), 64'd0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(4);
    do_check("lit_after_rst_pat", 64'(pat_out), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
